fifo_umbrales: RTL and testbench

- Per-lane buffer FIFO for the transaction layer.
- Stores TLP data words.
- Compares its fill level against the thresholds that the control state machine latches during INIT, and raises the corresponding flags.
- Its empty flag is one bit of the 8-bit empties vector that feeds back to the control state machine.
- Eight instances sit downstream of the control state machine, one per lane.

---
 rtl/fifo_umbrales_if.sv | 30 +++
 rtl/fifo_umbrales.sv | 79 +++++++
 tb/tb_fifo_umbrales.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_umbrales_if.sv
// Interface bundling the per-lane FIFO handshake, threshold inputs and status outputs.
// The master drives push/pop/data/thresholds; the slave (the FIFO) drives data and flags.
interface fifo_umbrales_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [2:0]            Umbral_superior;
    logic [2:0]            Umbral_inferior;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;

    modport master (
        output push, pop, data_in, Umbral_superior, Umbral_inferior,
        input  data_out, valid_out, count, full, empty, almost_full, almost_empty, error
    );

    modport slave (
        input  push, pop, data_in, Umbral_superior, Umbral_inferior,
        output data_out, valid_out, count, full, empty, almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_umbrales.sv
// Per-lane TLP word FIFO with almost-full/almost-empty threshold flags and a
// sticky overflow/underflow error bit; its empty flag feeds the lane controller.
module fifo_umbrales #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    fifo_umbrales_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_err_ev;
    logic [CW-1:0] w_sup;
    logic [CW-1:0] w_inf;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is only legal when a pop frees the slot in the same edge.
    assign w_pop_ok  = bus.pop & ~w_empty;
    assign w_push_ok = bus.push & (~w_full | w_pop_ok);
    assign w_err_ev  = (bus.push & w_full & ~w_pop_ok) | (bus.pop & w_empty);

    assign w_sup = CW'(bus.Umbral_superior);
    assign w_inf = CW'(bus.Umbral_inferior);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            r_valid_out <= w_pop_ok;
            r_count     <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            if (w_err_ev) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.valid_out    = r_valid_out;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (w_sup != '0) & (r_count >= w_sup);
    assign bus.almost_empty = (w_inf != '0) & (r_count <= w_inf);
    assign bus.error        = r_error;
endmodule

// File: tb/tb_fifo_umbrales.sv
// Bench for fifo_umbrales: a queue model of the FIFO plus a scoreboard of expected
// read words, driven from a vector table and a few hand-written sequences.
module tb_fifo_umbrales;
    logic clk;
    logic reset;

    fifo_umbrales_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();

    fifo_umbrales #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [9:0] mq    [$];
    logic [9:0] exp_q [$];
    logic       m_err;

    typedef struct {
        logic       p;
        logic       q;
        logic [9:0] d;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_flags();
        int c;
        int sup;
        int inf;
        c   = mq.size();
        sup = int'(bus.Umbral_superior);
        inf = int'(bus.Umbral_inferior);
        chk("count",        32'(bus.count),        32'(c));
        chk("full",         32'(bus.full),         32'(c == 8));
        chk("empty",        32'(bus.empty),        32'(c == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(sup != 0 && c >= sup));
        chk("almost_empty", 32'(bus.almost_empty), 32'(inf != 0 && c <= inf));
        chk("error",        32'(bus.error),        32'(m_err));
    endtask

    // One clock: drive push/pop/data, update the model, check everything after the edge.
    task automatic cyc(input logic p, input logic q, input logic [9:0] d);
        logic pop_ok;
        logic push_ok;
        logic [9:0] w;
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        pop_ok  = q && (mq.size() != 0);
        push_ok = p && (mq.size() != 8 || pop_ok);
        if ((p && !push_ok) || (q && mq.size() == 0)) m_err = 1'b1;
        if (pop_ok) exp_q.push_back(mq.pop_front());
        if (push_ok) mq.push_back(d);
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        if (pop_ok) begin
            chk("valid_out", 32'(bus.valid_out), 32'd1);
            w = exp_q.pop_front();
            chk("data_out", 32'(bus.data_out), 32'(w));
        end else begin
            chk("valid_out_idle", 32'(bus.valid_out), 32'd0);
        end
        chk_flags();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        exp_q.delete();
        m_err = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk_flags();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = '0;
        bus.Umbral_superior = 3'd6;
        bus.Umbral_inferior = 3'd2;
        m_err = 1'b0;

        for (int k = 1; k <= 6; k++) begin
            vecs[k-1].p     = 1'b1;
            vecs[k-1].q     = 1'b0;
            vecs[k-1].d     = 10'(k);
            vecs[k-1].cnt   = 4'(k);
            vecs[k-1].full  = 1'b0;
            vecs[k-1].empty = 1'b0;
            vecs[k-1].af    = (k >= 6);
            vecs[k-1].ae    = (k <= 2);
        end

        // Reset state with thresholds 6/2.
        #3;
        chk("init_empty", 32'(bus.empty), 32'd1);
        chk("init_ae", 32'(bus.almost_empty), 32'd1);
        chk("init_af", 32'(bus.almost_full), 32'd0);
        chk("init_full", 32'(bus.full), 32'd0);
        chk("init_err", 32'(bus.error), 32'd0);
        chk("init_valid", 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_flags();

        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].p, vecs[i].q, vecs[i].d);
            chk("vec_count", 32'(bus.count), 32'(vecs[i].cnt));
            chk("vec_full", 32'(bus.full), 32'(vecs[i].full));
            chk("vec_empty", 32'(bus.empty), 32'(vecs[i].empty));
            chk("vec_af", 32'(bus.almost_full), 32'(vecs[i].af));
            chk("vec_ae", 32'(bus.almost_empty), 32'(vecs[i].ae));
        end

        cyc(1'b1, 1'b0, 10'h007);
        cyc(1'b1, 1'b0, 10'h008);
        chk("full_at_8", 32'(bus.full), 32'd1);
        cyc(1'b1, 1'b0, 10'h3FF);
        chk("overflow_err", 32'(bus.error), 32'd1);
        chk("overflow_count", 32'(bus.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 10'h000);
            chk("drain_order", 32'(bus.data_out), 32'(i + 1));
        end
        chk("drained_empty", 32'(bus.empty), 32'd1);
        cyc(1'b0, 1'b0, 10'h000);

        // Full FIFO under simultaneous push and pop, across pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'(10'h100 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 10'(10'h200 + i));
            chk("full_pp_count", 32'(bus.count), 32'd8);
            chk("full_pp_err", 32'(bus.error), 32'd0);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 10'h000);

        // Empty FIFO under simultaneous push and pop: no bypass, underflow flagged.
        do_reset();
        cyc(1'b1, 1'b1, 10'h2A5);
        chk("empty_pp_count", 32'(bus.count), 32'd1);
        chk("empty_pp_err", 32'(bus.error), 32'd1);
        chk("empty_pp_valid", 32'(bus.valid_out), 32'd0);
        cyc(1'b0, 1'b1, 10'h000);
        chk("empty_pp_word", 32'(bus.data_out), 32'h2A5);

        // Thresholds disabled across every occupancy.
        do_reset();
        bus.Umbral_superior = 3'd0;
        bus.Umbral_inferior = 3'd0;
        #1;
        chk("dis_ae_0", 32'(bus.almost_empty), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 10'(10'h050 + i));
            chk("dis_af", 32'(bus.almost_full), 32'd0);
            chk("dis_ae", 32'(bus.almost_empty), 32'd0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 10'h000);
        chk("five_stored", 32'(bus.count), 32'd5);

        // Asynchronous reset with words stored, then first push lands in a fresh FIFO.
        bus.Umbral_inferior = 3'd4;
        do_reset();
        chk("async_ae", 32'(bus.almost_empty), 32'd1);
        cyc(1'b1, 1'b0, 10'h155);
        cyc(1'b0, 1'b1, 10'h000);
        chk("post_rst_word", 32'(bus.data_out), 32'h155);
        cyc(1'b0, 1'b0, 10'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
